scan_rx: RTL and testbench
==========================

Name: scan_rx

Overview:
- Receive-side counterpart of the print path: accepts ASCII bytes from the UART receiver and delivers them to DCP.
- Two modes: a single raw byte, or a 32-bit word typed as up to 8 hex digits.
- Sits between the rx module (vld_rx/d_rx, rdy_rx) and DCP (req_rx/type_rx, ack_rx/din_rx).
- Mirrors print-side formatting: the '_' separator is accepted and ignored.

Parameters:
- TERM_CHAR, 8'h0D, primary word terminator (CR).
- ALT_TERM_CHAR, 8'h20, secondary word terminator (space).
- MAX_DIGITS, 8, number of hex digits retained (value fixed at 8 for a 32-bit result).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- req_rx  input  1  request to scan (from DCP); level signal, rising edge starts a transaction.
- type_rx  input  1  0 = Byte, 1 = Word (from DCP); sampled on the req_rx rising edge.
- vld_rx  input  1  received byte valid (from rx); one-cycle pulse.
- d_rx  input  8  received byte (from rx); valid when vld_rx=1.
- rdy_rx  output  1  ready to accept bytes (to rx).
- din_rx  output  32  scanned result (to DCP).
- err_rx  output  1  word aborted by an illegal character (to DCP).
- ack_rx  output  1  transaction complete (to DCP).

Behaviour:
- Reset (async, rstn=0): state=IDLE; rdy_rx=0, ack_rx=0, err_rx=0, din_rx=0, digit count=0, edge detector cleared. Reset mid-transaction discards partial data.
- req_rx rising-edge detection is registered internally. Rising edges outside IDLE are ignored.
- States: IDLE, BYTE, WORD, DONE.
- IDLE:
  - On a req_rx rising edge, clear din_rx, err_rx and digit count.
  - type_rx=0 -> BYTE; type_rx=1 -> WORD.
  - rdy_rx rises the cycle after the edge.
- BYTE:
  - rdy_rx=1.
  - On vld_rx: din_rx={24'h0,d_rx}; go to DONE.
  - ack_rx=1 and rdy_rx=0 on the next cycle (one-cycle latency). Any byte value is accepted.
- WORD (rdy_rx=1), per vld_rx byte:
  - Hex digit '0'-'9', 'a'-'f', 'A'-'F': din_rx <= {din_rx[27:0], nibble}; count increments, saturating at 8. More than 8 digits keeps the last 8 (older digits shift out).
  - '_' (8'h5F): ignored, no state change.
  - TERM_CHAR or ALT_TERM_CHAR with count>=1: go to DONE with err_rx=0.
  - Terminator with count=0: ignored, so leading spaces or CR are skipped.
  - Any other byte: go to DONE with err_rx=1; din_rx holds the partial value.
- DONE:
  - ack_rx=1, rdy_rx=0; bytes arriving on vld_rx are dropped.
  - ack_rx, din_rx and err_rx hold until req_rx=0, then go to IDLE with ack_rx=0 (4-phase handshake).
  - din_rx and err_rx keep their values in IDLE until the next request.
- If req_rx falls while in BYTE or WORD: abort to IDLE, rdy_rx=0, no ack.
- If vld_rx and a req_rx edge occur in the same cycle in IDLE: the byte is dropped, because rdy_rx was 0.
- ack_rx is never asserted for less than one full cycle and never while rdy_rx=1.

Optional Feature:
- Macro SCAN_BACKSPACE_EN.
- Defined: in WORD, byte 8'h08 or 8'h7F removes the last digit: din_rx <= {4'h0,din_rx[31:4]}, count decrements. At count=0 the byte is ignored. Removed digits that had already shifted out beyond 8 are not recovered.
- Not defined: 8'h08 and 8'h7F are illegal characters, giving DONE with err_rx=1.

Test Plan:
- Byte mode: req_rx rising with type_rx=0, then vld_rx with d_rx=8'h41 -> next cycle ack_rx=1, din_rx=32'h00000041, rdy_rx=0. Drop req_rx -> ack_rx=0 the next cycle.
- Word mode: send "1234_abCD" then 8'h0D -> ack_rx=1, din_rx=32'h1234ABCD, err_rx=0.
- Leading and overflow: send " ", "0", "123456789", " " -> din_rx=32'h23456789, err_rx=0. The leading space is ignored.
- Illegal character: send "12G" -> ack_rx after 'G', err_rx=1, din_rx=32'h00000012.
- Abort and reset: send "AB", drop req_rx -> IDLE, no ack. Repeat and pulse rstn low mid-word -> all outputs 0 and the new request starts clean.
- With SCAN_BACKSPACE_EN: send "12", 8'h08, "3", CR -> din_rx=32'h00000013. Without it, the same input gives err_rx=1 and din_rx=32'h00000012.

Source files
------------

// File: rtl/scan_rx_if.sv
// Handshake bundle between DCP/rx (master side) and the scan_rx receiver (slave side).
interface scan_rx_if;
  logic        req_rx;
  logic        type_rx;
  logic        vld_rx;
  logic [7:0]  d_rx;
  logic        rdy_rx;
  logic [31:0] din_rx;
  logic        err_rx;
  logic        ack_rx;

  modport master (
    output req_rx, type_rx, vld_rx, d_rx,
    input  rdy_rx, din_rx, err_rx, ack_rx
  );

  modport slave (
    input  req_rx, type_rx, vld_rx, d_rx,
    output rdy_rx, din_rx, err_rx, ack_rx
  );
endinterface

// File: rtl/scan_rx.sv
// ASCII scanner: one raw byte or up to 8 hex digits into a 32-bit word for DCP.
// Optional macro SCAN_BACKSPACE_EN: 8'h08 / 8'h7F delete the last hex digit in word mode.
module scan_rx #(
  parameter logic [7:0] TERM_CHAR     = 8'h0D,
  parameter logic [7:0] ALT_TERM_CHAR = 8'h20,
  parameter int         MAX_DIGITS    = 8
) (
  input  logic     clk,
  input  logic     rstn,
  scan_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BYTE, WORD, DONE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic        req_prev_q, req_prev_d;
  logic        rdy_q, rdy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        req_rise;
  logic        hex_vld;
  logic [3:0]  hex_nib;
  logic [7:0]  hex_off;

  // Hex digit decode: offset subtracted depends on which ASCII range matched.
  always_comb begin
    hex_vld = 1'b1;
    hex_off = 8'h00;
    if (bus.d_rx >= 8'h30 && bus.d_rx <= 8'h39) begin
      hex_off = bus.d_rx - 8'h30;
    end else if (bus.d_rx >= 8'h61 && bus.d_rx <= 8'h66) begin
      hex_off = bus.d_rx - 8'h57;
    end else if (bus.d_rx >= 8'h41 && bus.d_rx <= 8'h46) begin
      hex_off = bus.d_rx - 8'h37;
    end else begin
      hex_vld = 1'b0;
    end
    hex_nib = hex_off[3:0];
  end

  always_comb begin
    state_d    = state_q;
    req_prev_d = bus.req_rx;
    rdy_d      = rdy_q;
    ack_d      = ack_q;
    err_d      = err_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    req_rise   = bus.req_rx & ~req_prev_q;

    case (state_q)
      IDLE: begin
        rdy_d = 1'b0;
        ack_d = 1'b0;
        if (req_rise) begin
          din_d   = 32'h0;
          err_d   = 1'b0;
          cnt_d   = 4'd0;
          rdy_d   = 1'b1;
          state_d = bus.type_rx ? WORD : BYTE;
        end
      end

      BYTE: begin
        if (!bus.req_rx) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.vld_rx) begin
          din_d   = {24'h0, bus.d_rx};
          rdy_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = DONE;
        end
      end

      WORD: begin
        if (!bus.req_rx) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end else if (bus.vld_rx) begin
          if (hex_vld) begin
            din_d = {din_q[27:0], hex_nib};
            if (cnt_q < MAX_CNT) begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (bus.d_rx == 8'h5F) begin
            // Digit-group separator carries no information.
          end else if (bus.d_rx == TERM_CHAR || bus.d_rx == ALT_TERM_CHAR) begin
            if (cnt_q != 4'd0) begin
              err_d   = 1'b0;
              rdy_d   = 1'b0;
              ack_d   = 1'b1;
              state_d = DONE;
            end
`ifdef SCAN_BACKSPACE_EN
          end else if (bus.d_rx == 8'h08 || bus.d_rx == 8'h7F) begin
            if (cnt_q != 4'd0) begin
              din_d = {4'h0, din_q[31:4]};
              cnt_d = cnt_q - 4'd1;
            end
`endif
          end else begin
            err_d   = 1'b1;
            rdy_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        rdy_d = 1'b0;
        if (!bus.req_rx) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        rdy_d   = 1'b0;
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      rdy_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      din_q      <= 32'h0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      rdy_q      <= rdy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rdy_rx = rdy_q;
  assign bus.ack_rx = ack_q;
  assign bus.err_rx = err_q;
  assign bus.din_rx = din_q;

endmodule

// File: tb/tb_scan_rx.sv
// Scoreboard bench for scan_rx: expected words queued at stimulus, compared on each ack rise.
module tb_scan_rx;

  typedef struct packed {
    logic [31:0] din;
    logic        err;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   txn_cnt;
  exp_t sb[$];
  exp_t e_m;
  logic ack_prev;

  scan_rx_if bus ();

  scan_rx dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: ack must never coexist with rdy; each ack rise consumes one scoreboard entry.
  always @(negedge clk) begin
    if (bus.ack_rx === 1'b1) chk("ack_vs_rdy", 32'(bus.rdy_rx), 0);
    if (bus.ack_rx === 1'b1 && ack_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e_m = sb.pop_front();
        txn_cnt++;
        $display("txn %0d: din=%h err=%b (exp din=%h err=%b)", txn_cnt,
                 bus.din_rx, bus.err_rx, e_m.din, e_m.err);
        chk("din", bus.din_rx, e_m.din);
        chk("err", 32'(bus.err_rx), 32'(e_m.err));
      end
    end
    ack_prev = bus.ack_rx;
  end

  task automatic start(input logic t);
    @(posedge clk); #1;
    bus.req_rx  = 1'b1;
    bus.type_rx = t;
    @(posedge clk); #1;
    chk("rdy_up", 32'(bus.rdy_rx), 1);
  endtask

  task automatic send(input logic [7:0] b);
    bus.vld_rx = 1'b1;
    bus.d_rx   = b;
    @(posedge clk); #1;
    bus.vld_rx = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (bus.ack_rx !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.ack_rx !== 1'b1) chk("ack_timeout", 0, 1);
  endtask

  task automatic finish_txn(input logic [31:0] din_exp);
    bus.req_rx = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", 32'(bus.ack_rx), 0);
    @(posedge clk); #1;
    chk("din_hold_idle", bus.din_rx, din_exp);
  endtask

  task automatic word_txn(input string s, input logic [31:0] din, input logic err);
    sb.push_back(exp_t'{din: din, err: err});
    start(1'b1);
    send_str(s);
    wait_ack();
    send(8'h39);  // dropped while in DONE
    finish_txn(din);
  endtask

  task automatic byte_txn(input logic [7:0] b);
    sb.push_back(exp_t'{din: {24'h0, b}, err: 1'b0});
    start(1'b0);
    bus.vld_rx = 1'b1;
    bus.d_rx   = b;
    @(posedge clk); #1;
    bus.vld_rx = 1'b0;
    chk("byte_ack", 32'(bus.ack_rx), 1);
    chk("byte_rdy", 32'(bus.rdy_rx), 0);
    wait_ack();
    finish_txn({24'h0, b});
  endtask

  initial begin
    checks = 0; errors = 0; txn_cnt = 0; ack_prev = 1'b0;
    rstn = 1'b0;
    bus.req_rx = 1'b0; bus.type_rx = 1'b0; bus.vld_rx = 1'b0; bus.d_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.rdy_rx), 0);
    chk("rst_ack", 32'(bus.ack_rx), 0);
    chk("rst_err", 32'(bus.err_rx), 0);
    chk("rst_din", bus.din_rx, 0);
    rstn = 1'b1;

    byte_txn(8'h41);
    byte_txn(8'hFF);
    byte_txn(8'h0D);

    sb.push_back(exp_t'{din: 32'h1234ABCD, err: 1'b0});
    start(1'b1);
    send_str("1234_abCD");
    send(8'h0D);
    wait_ack();
    finish_txn(32'h1234ABCD);

    word_txn(" 0123456789 ", 32'h23456789, 1'b0);
    word_txn("12G", 32'h00000012, 1'b1);
    word_txn("_ F ", 32'h0000000F, 1'b0);

`ifdef SCAN_BACKSPACE_EN
    sb.push_back(exp_t'{din: 32'h00000013, err: 1'b0});
`else
    sb.push_back(exp_t'{din: 32'h00000012, err: 1'b1});
`endif
    start(1'b1);
    send_str("12");
    send(8'h08);
    send_str("3");
    send(8'h0D);
    wait_ack();
`ifdef SCAN_BACKSPACE_EN
    finish_txn(32'h00000013);
`else
    finish_txn(32'h00000012);
`endif

    // Abort by dropping req mid-word: no ack may follow.
    start(1'b1);
    send_str("AB");
    bus.req_rx = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_noack", 32'(bus.ack_rx), 0);
    end
    chk("abort_rdy", 32'(bus.rdy_rx), 0);

    // Asynchronous reset mid-word.
    start(1'b1);
    send_str("AB");
    chk("partial_din", bus.din_rx, 32'h000000AB);
    rstn = 1'b0;
    #1;
    chk("midrst_din", bus.din_rx, 0);
    chk("midrst_rdy", 32'(bus.rdy_rx), 0);
    chk("midrst_ack", 32'(bus.ack_rx), 0);
    bus.req_rx = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    word_txn("5 ", 32'h00000005, 1'b0);

    // Byte coinciding with the req edge is dropped because rdy was still low.
    sb.push_back(exp_t'{din: 32'h00000005, err: 1'b0});
    @(posedge clk); #1;
    bus.req_rx = 1'b1; bus.type_rx = 1'b1;
    bus.vld_rx = 1'b1; bus.d_rx = 8'h37;
    @(posedge clk); #1;
    bus.vld_rx = 1'b0;
    chk("edge_rdy", 32'(bus.rdy_rx), 1);
    send(8'h35);
    send(8'h0D);
    wait_ack();
    finish_txn(32'h00000005);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
